des_key_sched_seq: RTL and testbench

- Iterative DES/3DES round-key generator. It replaces the fully unrolled 16-stage combinational subkey tree with one C/D register pair that emits one 48-bit subkey per accepted handshake.
- It supports NKEY selectable key slots for 3DES keying options and an encrypt/decrypt mode. Decrypt emits K16..K1 using right rotations, so no key storage is needed.
- It sits between the key register file and the round datapath of the iterative DES core.

---
 rtl/des_pkg.sv | 66 ++++++
 rtl/des_cd_rotate.sv | 20 ++
 rtl/des_key_sched_seq.sv | 138 +++++++++++++
 tb/tb_des_key_sched_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants and permutation helpers.
// Shared by the iterative round-key generator and its rotator.
package des_pkg;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // SHIFT_SCHED[r-1] is the left-rotate amount that produces round r.
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Table entries use DES numbering: bit 1 is the MSB.
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] r;
    cd = {c, d};
    r  = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  // Step after round cnt+1 while encrypting: rotate left by s[cnt+2].
  function automatic logic [1:0] enc_shift(input logic [3:0] cnt);
    logic [3:0] n;
    n = cnt + 4'd1;
    return SHIFT_SCHED[n];
  endfunction

  // Step after round 16-cnt while decrypting: rotate right by s[16-cnt].
  function automatic logic [1:0] dec_shift(input logic [3:0] cnt);
    logic [3:0] n;
    n = 4'd15 - cnt;
    return SHIFT_SCHED[n];
  endfunction

endpackage

// File: rtl/des_cd_rotate.sv
// 28-bit C/D half rotator: rotates by 0, 1 or 2 bits, left (dir=0) or right (dir=1).
module des_cd_rotate (
  input  logic [27:0] din,
  input  logic [1:0]  amt,
  input  logic        dir,
  output logic [27:0] dout
);

  always_comb begin
    dout = din;
    case ({dir, amt})
      3'b001:  dout = {din[26:0], din[27]};
      3'b010:  dout = {din[25:0], din[27:26]};
      3'b101:  dout = {din[0], din[27:1]};
      3'b110:  dout = {din[1:0], din[27:2]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/des_key_sched_seq.sv
// Iterative DES/3DES round-key generator: one C/D register pair, one subkey per
// sk_valid/sk_ready handshake, K1..K16 or K16..K1 depending on decrypt.
module des_key_sched_seq
  import des_pkg::*;
#(
  parameter int NKEY  = 3,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [64*NKEY-1:0]   key_in,
  input  logic [SEL_W-1:0]     key_sel,
  input  logic                 decrypt,
  input  logic                 start,
  input  logic                 abort,
  output logic                 ready,
  output logic [47:0]          sk,
  output logic [3:0]           sk_idx,
  output logic                 sk_valid,
  input  logic                 sk_ready,
  output logic                 sk_last,
  output logic                 done,
  output logic                 err
);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [63:0] key_slot;
  logic        sel_ok;
  logic [55:0] cd0;
  logic [27:0] c_src, d_src, c_rot, d_rot;
  logic [1:0]  rot_amt;
  logic        rot_dir;

  always_comb begin
    key_slot = '0;
    for (int i = 0; i < NKEY; i++)
      if (int'(key_sel) == i) key_slot = key_in[64*i +: 64];
  end

  assign sel_ok = int'(key_sel) < NKEY;
  assign cd0    = pc1(key_slot);

  // In IDLE the rotators pre-shift the freshly permuted key so the first
  // subkey is ready the cycle after start; in RUN they advance C/D.
  always_comb begin
    if (state_q == IDLE) begin
      c_src   = cd0[55:28];
      d_src   = cd0[27:0];
      rot_amt = decrypt ? 2'd0 : SHIFT_SCHED[0];
      rot_dir = 1'b0;
    end else begin
      c_src   = c_q;
      d_src   = d_q;
      rot_amt = dec_q ? dec_shift(cnt_q) : enc_shift(cnt_q);
      rot_dir = dec_q;
    end
  end

  des_cd_rotate u_rot_c (.din(c_src), .amt(rot_amt), .dir(rot_dir), .dout(c_rot));
  des_cd_rotate u_rot_d (.din(d_src), .amt(rot_amt), .dir(rot_dir), .dout(d_rot));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (sel_ok) begin
            c_d     = c_rot;
            d_d     = d_rot;
            dec_d   = decrypt;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sk_ready) begin
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            c_d   = c_rot;
            d_d   = d_rot;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == IDLE);
    sk_valid = (state_q == RUN);
    sk       = sk_valid ? pc2(c_q, d_q) : '0;
    sk_idx   = sk_valid ? (dec_q ? 4'd15 - cnt_q : cnt_q) : '0;
    sk_last  = sk_valid && (cnt_q == 4'd15);
    done     = done_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Scoreboard bench for des_key_sched_seq: a cumulative-rotation DES key model
// fills an expectation queue at each start; a negedge monitor pops on handshakes.
module tb_des_key_sched_seq;

  localparam int NKEY  = 3;
  localparam int SEL_W = 2;

  localparam int TB_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TB_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int TB_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [64*NKEY-1:0]  key_in;
  logic [SEL_W-1:0]    key_sel;
  logic                decrypt, start, abort, sk_ready;
  logic                ready, sk_valid, sk_last, done, err;
  logic [47:0]         sk;
  logic [3:0]          sk_idx;

  des_key_sched_seq #(.NKEY(NKEY), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_sel(key_sel),
    .decrypt(decrypt), .start(start), .abort(abort), .ready(ready),
    .sk(sk), .sk_idx(sk_idx), .sk_valid(sk_valid), .sk_ready(sk_ready),
    .sk_last(sk_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [63:0] keys [NKEY];
  logic [47:0] obs_sk [16];
  logic [47:0] enc_ref [16];
  int          n_chk = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic        throttle = 1'b0;
  logic        stall_p = 1'b0;
  logic [47:0] stall_sk;
  logic [3:0]  stall_idx;
  logic        stall_last;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {x, x};
    return t[55-n -: 28];
  endfunction

  // Round r key from C0/D0 rotated by the cumulative shift up to round r.
  function automatic logic [47:0] model_k(input logic [63:0] key, input int r);
    logic [55:0] cd, cdr;
    logic [27:0] c, d;
    logic [47:0] k;
    int          cum;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-TB_PC1[i]];
    cum = 0;
    for (int j = 0; j < r; j++) cum += TB_SHIFTS[j];
    c   = rotl28(cd[55:28], cum % 28);
    d   = rotl28(cd[27:0], cum % 28);
    cdr = {c, d};
    k   = '0;
    for (int i = 0; i < 48; i++) k[47-i] = cdr[56-TB_PC2[i]];
    return k;
  endfunction

  initial begin
    sk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sk_ready = throttle ? ($urandom_range(0, 99) >= 40) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (stall_p && sk_valid) begin
      check("stall_sk", sk, stall_sk);
      check("stall_idx", sk_idx, stall_idx);
      check("stall_last", sk_last, stall_last);
    end
    stall_p = 1'b0;
    if (sk_valid && sk_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_sk", sk, mon_e.sk);
        check("sb_idx", sk_idx, mon_e.idx);
        check("sb_last", sk_last, mon_e.last);
      end
      if (hs_cnt < 16) obs_sk[hs_cnt] = sk;
      hs_cnt++;
    end else if (sk_valid) begin
      stall_p    = 1'b1;
      stall_sk   = sk;
      stall_idx  = sk_idx;
      stall_last = sk_last;
    end
  end

  // Called at posedge+1 with ready high; returns at posedge+1 after acceptance.
  task automatic start_sched(input int sel, input logic dec);
    exp_t e;
    int   r;
    key_sel = SEL_W'(sel);
    decrypt = dec;
    start   = 1'b1;
    hs_cnt  = 0;
    if (sel < NKEY) begin
      for (int j = 0; j < 16; j++) begin
        r      = dec ? 16 - j : j + 1;
        e.sk   = model_k(keys[sel], r);
        e.idx  = 4'(r - 1);
        e.last = (j == 15);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (sel < NKEY) check("lat_valid", sk_valid, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_hs"}, hs_cnt, 16);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  initial begin
    int          dc;
    logic [64*NKEY-1:0] saved;
    keys[0] = 64'h133457799BBCDFF1;
    keys[1] = 64'h0E329232EA6D0D73;
    keys[2] = 64'hA1B2C3D4E5F60718;
    key_in  = {keys[2], keys[1], keys[0]};
    key_sel = '0;
    decrypt = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;

    #3;
    check("rst_ready", ready, 1);
    check("rst_valid", sk_valid, 0);
    check("rst_sk", sk, 0);
    check("rst_idx", sk_idx, 0);
    check("rst_last", sk_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Encrypt reference key
    start_sched(0, 1'b0);
    check("k1_const", sk, 48'h1B02EFFC7072);
    check("k1_idx", sk_idx, 0);
    wait_done("enc");
    check("k16_const", obs_sk[15], 48'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) enc_ref[i] = obs_sk[i];

    // Decrypt reference key
    start_sched(0, 1'b1);
    check("dec_first", sk, 48'hCB3D8B0E17F5);
    check("dec_first_idx", sk_idx, 15);
    wait_done("dec");
    check("dec_last", obs_sk[15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) check("dec_rev", obs_sk[i], enc_ref[15-i]);

    // Back-to-back slots; mid-run start with changed inputs must be ignored
    for (int s = 0; s < NKEY; s++) begin
      start_sched(s, s == 2);
      if (s == 1) begin
        @(posedge clk);
        #1;
        saved   = key_in;
        key_in  = ~key_in;
        key_sel = 2'd2;
        decrypt = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        key_in  = saved;
      end
      wait_done("slot");
    end

    // Invalid slot
    key_sel = 2'd3;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_ready", ready, 1);
    check("err_valid", sk_valid, 0);
    @(posedge clk);
    #1;
    check("err_clear", err, 0);
    check("err_valid2", sk_valid, 0);

    // abort + start in IDLE
    key_sel = 2'd0;
    abort   = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    check("abst_valid", sk_valid, 0);
    check("abst_ready", ready, 1);
    check("abst_err", err, 0);

    // Throttled consumer
    throttle = 1'b1;
    start_sched(0, 1'b0);
    wait_done("thr");
    throttle = 1'b0;
    for (int i = 0; i < 16; i++) check("thr_seq", obs_sk[i], enc_ref[i]);
    repeat (2) @(posedge clk);
    #1;

    // abort at the 5th subkey
    start_sched(1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ab_idx", sk_idx, 4);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("ab_valid", sk_valid, 0);
    check("ab_ready", ready, 1);
    check("ab_done", done, 0);
    exp_q.delete();
    dc = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("ab_nodone", done_cnt, dc);
    start_sched(0, 1'b0);
    check("ab_k1", sk, 48'h1B02EFFC7072);
    wait_done("post_ab");

    // abort with the final handshake
    start_sched(2, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    check("abl_last", sk_last, 1);
    check("abl_idx", sk_idx, 15);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abl_done", done, 0);
    check("abl_ready", ready, 1);
    check("abl_valid", sk_valid, 0);
    check("abl_qempty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("abl_done2", done, 0);

    // Asynchronous reset mid-schedule
    start_sched(0, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", sk_valid, 0);
    check("arst_sk", sk, 0);
    check("arst_idx", sk_idx, 0);
    check("arst_last", sk_last, 0);
    check("arst_ready", ready, 1);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_sched(0, 1'b0);
    wait_done("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
